// File: rtl/ml_ahb_mst_req_if.sv
// Signal bundle between one AHB master, its request block and the per-port arbiters/slaves.
// The master modport is the request block's view; slave is the view of the surrounding fabric.
interface ml_ahb_mst_req_if #(
    parameter int unsigned NB_SLAVE_PORT = 2
);
    logic [1:0]                  m_htrans;
    logic [31:0]                 m_haddr;
    logic                        m_hwrite;
    logic [2:0]                  m_hsize;
    logic [2:0]                  m_hburst;
    logic [31:0]                 m_hwdata;
    logic                        m_hready;
    logic [31:0]                 m_hrdata;
    logic [1:0]                  m_hresp;

    logic [NB_SLAVE_PORT-1:0]    mx_sel;
    logic                        mx_htrans0;
    logic [1:0]                  s_htrans;
    logic [31:0]                 s_haddr;
    logic                        s_hwrite;
    logic [2:0]                  s_hsize;
    logic [2:0]                  s_hburst;
    logic [31:0]                 s_hwdata;
    logic [NB_SLAVE_PORT-1:0]    mx_arb_grant;
    logic [NB_SLAVE_PORT-1:0]    s_hready;
    logic [32*NB_SLAVE_PORT-1:0] s_hrdata;
    logic [2*NB_SLAVE_PORT-1:0]  s_hresp;

    modport master (
        input  m_htrans, m_haddr, m_hwrite, m_hsize, m_hburst, m_hwdata,
        output m_hready, m_hrdata, m_hresp,
        output mx_sel, mx_htrans0, s_htrans, s_haddr, s_hwrite, s_hsize, s_hburst, s_hwdata,
        input  mx_arb_grant, s_hready, s_hrdata, s_hresp
    );

    modport slave (
        output m_htrans, m_haddr, m_hwrite, m_hsize, m_hburst, m_hwdata,
        input  m_hready, m_hrdata, m_hresp,
        input  mx_sel, mx_htrans0, s_htrans, s_haddr, s_hwrite, s_hsize, s_hburst, s_hwdata,
        output mx_arb_grant, s_hready, s_hrdata, s_hresp
    );
endinterface

// File: rtl/ml_ahb_mst_req.sv
// Master-side request stage of an AHB matrix: decodes the target port, holds an address
// that the port cannot take yet, and steers the selected port's data-phase response back.
module ml_ahb_mst_req #(
    parameter int unsigned NB_SLAVE_PORT = 2,
    parameter int unsigned DECODE_BIT    = 28
) (
    input logic              hclk,
    input logic              reset,
    ml_ahb_mst_req_if.master bus
);
    localparam logic [1:0] HTRANS_IDLE = 2'b00;
    localparam logic [1:0] HTRANS_NSEQ = 2'b10;
    localparam logic [1:0] HRESP_OKAY  = 2'b00;

    typedef enum logic {PASS, HOLD} state_t;
    state_t state_q, state_d;

    logic [31:0] hold_addr;
    logic        hold_write;
    logic [2:0]  hold_size;
    logic [2:0]  hold_burst;
    logic        dp_valid;
    logic        dp_port;

    logic [1:0]  out_trans;
    logic [31:0] out_addr;
    logic        out_write;
    logic [2:0]  out_size;
    logic [2:0]  out_burst;
    logic        out_port;
    logic        port_go;
    logic        m_ready;
    logic        accept;
    logic        capture;
    logic        issue;
    logic        dp_done;
    logic [31:0] dp_rdata;
    logic [1:0]  dp_resp;

    always_ff @(posedge hclk or posedge reset) begin
        if (reset) state_q <= PASS;
        else       state_q <= state_d;
    end

    // Response mux for the port that owns the current data phase.
    always_comb begin
        dp_rdata = '0;
        dp_resp  = HRESP_OKAY;
        for (int unsigned p = 0; p < NB_SLAVE_PORT; p++) begin
            if (32'(dp_port) == p) begin
                dp_rdata = bus.s_hrdata[p*32 +: 32];
                dp_resp  = bus.s_hresp[p*2 +: 2];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        out_trans    = bus.m_htrans;
        out_addr     = bus.m_haddr;
        out_write    = bus.m_hwrite;
        out_size     = bus.m_hsize;
        out_burst    = bus.m_hburst;
        m_ready      = 1'b1;
        bus.m_hresp  = HRESP_OKAY;
        bus.m_hrdata = '0;
        accept       = 1'b0;
        capture      = 1'b0;
        issue        = 1'b0;
        dp_done      = 1'b0;

        if (state_q == HOLD) begin
            out_trans = HTRANS_NSEQ;
            out_addr  = hold_addr;
            out_write = hold_write;
            out_size  = hold_size;
            out_burst = hold_burst;
        end
        out_port = out_addr[DECODE_BIT];
        port_go  = bus.mx_arb_grant[out_port] && bus.s_hready[out_port];

        case (state_q)
            PASS: begin
                if (dp_valid) begin
                    m_ready      = bus.s_hready[dp_port];
                    bus.m_hresp  = dp_resp;
                    bus.m_hrdata = dp_rdata;
                end
                accept  = m_ready && bus.m_htrans[1];
                issue   = accept && port_go;
                capture = accept && !port_go;
                dp_done = !accept && dp_valid && bus.s_hready[dp_port];
                if (capture) state_d = HOLD;
            end
            HOLD: begin
                m_ready = 1'b0;
                issue   = port_go;
                if (port_go) state_d = PASS;
            end
            default: state_d = PASS;
        endcase
        bus.m_hready = m_ready;
    end

    // BUSY counts as active so the arbiter keeps the burst lock on the same port.
    always_comb begin
        bus.mx_sel = '0;
        for (int unsigned p = 0; p < NB_SLAVE_PORT; p++)
            bus.mx_sel[p] = (out_trans != HTRANS_IDLE) && (32'(out_port) == p);
    end

    assign bus.mx_htrans0 = out_trans[0];
    assign bus.s_htrans   = out_trans;
    assign bus.s_haddr    = out_addr;
    assign bus.s_hwrite   = out_write;
    assign bus.s_hsize    = out_size;
    assign bus.s_hburst   = out_burst;
    assign bus.s_hwdata   = bus.m_hwdata;

    always_ff @(posedge hclk or posedge reset) begin
        if (reset) begin
            hold_addr  <= '0;
            hold_write <= 1'b0;
            hold_size  <= '0;
            hold_burst <= '0;
            dp_valid   <= 1'b0;
            dp_port    <= 1'b0;
        end else begin
            if (capture) begin
                hold_addr  <= bus.m_haddr;
                hold_write <= bus.m_hwrite;
                hold_size  <= bus.m_hsize;
                hold_burst <= bus.m_hburst;
                dp_valid   <= 1'b0;
            end
            if (issue) begin
                dp_valid <= 1'b1;
                dp_port  <= out_port;
            end else if (dp_done) begin
                dp_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_ml_ahb_mst_req.sv
// Bench for ml_ahb_mst_req: directed scenarios plus a randomized run against a
// transaction-level model (pending-address queue and outstanding data-phase queue).
module tb_ml_ahb_mst_req;
    localparam int unsigned NB = 2;
    localparam int unsigned DB = 28;
    localparam logic [1:0]  IDLE = 2'b00;
    localparam logic [1:0]  BUSY = 2'b01;
    localparam logic [1:0]  NSEQ = 2'b10;
    localparam logic [1:0]  SEQ  = 2'b11;

    logic hclk  = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        logic [31:0] addr;
        logic        write;
        logic [2:0]  size;
        logic [2:0]  burst;
    } xfer_t;

    ml_ahb_mst_req_if #(.NB_SLAVE_PORT(NB)) bus ();

    ml_ahb_mst_req #(.NB_SLAVE_PORT(NB), .DECODE_BIT(DB)) dut (
        .hclk  (hclk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 hclk = ~hclk;

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic master_drive(input logic [1:0] trans, input logic [31:0] addr, input logic write);
        bus.m_htrans = trans;
        bus.m_haddr  = addr;
        bus.m_hwrite = write;
        bus.m_hsize  = 3'd2;
        bus.m_hburst = 3'd0;
    endtask

    task automatic bus_idle();
        master_drive(IDLE, 32'h0, 1'b0);
        bus.m_hwdata     = '0;
        bus.mx_arb_grant = '1;
        bus.s_hready     = '1;
        bus.s_hrdata     = '0;
        bus.s_hresp      = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus_idle();
        tick();
        settle();
        checks++;
        if ({bus.m_hready, bus.m_hresp, bus.mx_sel} !== {1'b1, 2'b00, 2'b00} || bus.m_hrdata !== 32'h0)
            begin errors++; $display("FAIL reset_outputs: got ready/resp/sel=%b rdata=%h, want 10000 rdata=0",
                {bus.m_hready, bus.m_hresp, bus.mx_sel}, bus.m_hrdata); end
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single_read();
        bus_idle();
        master_drive(NSEQ, 32'h0000_0100, 1'b0);
        settle();
        checks++;
        if ({bus.mx_sel, bus.s_htrans, bus.m_hready} !== {2'b01, NSEQ, 1'b1} || bus.s_haddr !== 32'h100)
            begin errors++; $display("FAIL single_addr: got sel/trans/ready=%b addr=%h, want 01101 addr=100",
                {bus.mx_sel, bus.s_htrans, bus.m_hready}, bus.s_haddr); end
        tick();
        master_drive(IDLE, 32'h0, 1'b0);
        bus.s_hrdata = {32'h5A5A_0002, 32'hA5A5_0001};
        settle();
        checks++;
        if (bus.m_hrdata !== 32'hA5A5_0001 || bus.m_hready !== 1'b1 || bus.mx_sel !== 2'b00)
            begin errors++; $display("FAIL single_data: got rdata=%h ready=%b sel=%b, want a5a50001 1 00",
                bus.m_hrdata, bus.m_hready, bus.mx_sel); end
        tick();
        settle();
        checks++;
        if (bus.m_hrdata !== 32'h0 || bus.m_hready !== 1'b1)
            begin errors++; $display("FAIL single_after: got rdata=%h ready=%b, want 0 1", bus.m_hrdata, bus.m_hready); end
    endtask

    task automatic test_hold();
        bus_idle();
        bus.mx_arb_grant = 2'b00;
        master_drive(NSEQ, 32'h1000_0000, 1'b1);
        settle();
        checks++;
        if (bus.m_hready !== 1'b1 || bus.mx_sel !== 2'b10)
            begin errors++; $display("FAIL hold_accept: got ready=%b sel=%b, want 1 10", bus.m_hready, bus.mx_sel); end
        for (int i = 0; i < 3; i++) begin
            tick();
            master_drive(IDLE, 32'h0, 1'b0);
            bus.m_hwdata     = 32'hDEAD_BEEF;
            bus.mx_arb_grant = (i == 2) ? 2'b10 : 2'b00;
            settle();
            checks++;
            if ({bus.m_hready, bus.m_hresp, bus.s_htrans, bus.mx_sel, bus.s_hwrite} !== {1'b0, 2'b00, NSEQ, 2'b10, 1'b1}
                || bus.s_haddr !== 32'h1000_0000 || bus.s_hwdata !== 32'hDEAD_BEEF)
                begin errors++; $display("FAIL hold_cycle%0d: got rdy/resp/trans/sel/wr=%b addr=%h wdata=%h, want 00010101 10000000 deadbeef",
                    i, {bus.m_hready, bus.m_hresp, bus.s_htrans, bus.mx_sel, bus.s_hwrite}, bus.s_haddr, bus.s_hwdata); end
        end
        tick();
        bus.mx_arb_grant = 2'b11;
        bus.s_hready     = 2'b01;
        bus.s_hrdata     = {32'h1111_2222, 32'h0};
        settle();
        checks++;
        if (bus.m_hready !== 1'b0 || bus.mx_sel !== 2'b00)
            begin errors++; $display("FAIL hold_dp_port1_wait: got ready=%b sel=%b, want 0 00", bus.m_hready, bus.mx_sel); end
        tick();
        bus.s_hready = 2'b11;
        settle();
        checks++;
        if (bus.m_hready !== 1'b1 || bus.m_hrdata !== 32'h1111_2222)
            begin errors++; $display("FAIL hold_dp_port1_done: got ready=%b rdata=%h, want 1 11112222", bus.m_hready, bus.m_hrdata); end
        tick();
        settle();
        checks++;
        if (bus.m_hrdata !== 32'h0)
            begin errors++; $display("FAIL hold_dp_cleared: got rdata=%h, want 0", bus.m_hrdata); end
    endtask

    task automatic test_busy_burst();
        logic [1:0]  tr [5] = '{NSEQ, BUSY, SEQ, SEQ, SEQ};
        logic [31:0] ad [5] = '{32'h200, 32'h204, 32'h204, 32'h208, 32'h20C};
        bus_idle();
        for (int i = 0; i < 5; i++) begin
            master_drive(tr[i], ad[i], 1'b0);
            bus.m_hburst = 3'b001;
            settle();
            checks++;
            if (bus.mx_sel !== 2'b01 || bus.mx_htrans0 !== (i != 0) || bus.m_hready !== 1'b1)
                begin errors++; $display("FAIL burst_beat%0d: got sel=%b htrans0=%b ready=%b, want 01 %0d 1",
                    i, bus.mx_sel, bus.mx_htrans0, bus.m_hready, (i != 0)); end
            tick();
        end
        master_drive(IDLE, 32'h0, 1'b0);
        tick();
    endtask

    task automatic test_port_switch();
        bus_idle();
        master_drive(NSEQ, 32'h0000_0300, 1'b0);
        tick();
        bus.s_hrdata = {32'h3333_4444, 32'h0000_0C0C};
        for (int i = 0; i < 2; i++) begin
            master_drive(NSEQ, 32'h1000_0040, 1'b0);
            bus.s_hready = 2'b10;
            settle();
            checks++;
            if (bus.m_hready !== 1'b0 || bus.m_hrdata !== 32'h0000_0C0C)
                begin errors++; $display("FAIL switch_stall%0d: got ready=%b rdata=%h, want 0 00000c0c",
                    i, bus.m_hready, bus.m_hrdata); end
            tick();
        end
        bus.s_hready = 2'b11;
        settle();
        checks++;
        if (bus.m_hready !== 1'b1 || bus.mx_sel !== 2'b10)
            begin errors++; $display("FAIL switch_issue: got ready=%b sel=%b, want 1 10", bus.m_hready, bus.mx_sel); end
        tick();
        master_drive(IDLE, 32'h0, 1'b0);
        settle();
        checks++;
        if (bus.m_hready !== 1'b1 || bus.m_hrdata !== 32'h3333_4444)
            begin errors++; $display("FAIL switch_dp_port1: got ready=%b rdata=%h, want 1 33334444", bus.m_hready, bus.m_hrdata); end
        tick();
    endtask

    task automatic test_error();
        bus_idle();
        master_drive(NSEQ, 32'h0000_0400, 1'b0);
        tick();
        master_drive(NSEQ, 32'h0000_0404, 1'b0);
        bus.s_hready = 2'b10;
        bus.s_hresp  = 4'b0001;
        settle();
        checks++;
        if ({bus.m_hready, bus.m_hresp} !== 3'b001)
            begin errors++; $display("FAIL error_cycle1: got ready/resp=%b, want 001", {bus.m_hready, bus.m_hresp}); end
        tick();
        master_drive(IDLE, 32'h0000_0404, 1'b0);
        bus.s_hready = 2'b11;
        settle();
        checks++;
        if ({bus.m_hready, bus.m_hresp, bus.mx_sel} !== 5'b10100)
            begin errors++; $display("FAIL error_cycle2: got ready/resp/sel=%b, want 10100", {bus.m_hready, bus.m_hresp, bus.mx_sel}); end
        tick();
        bus.s_hresp = '0;
        settle();
        checks++;
        if ({bus.m_hready, bus.m_hresp, bus.mx_sel} !== 5'b10000)
            begin errors++; $display("FAIL error_after: got ready/resp/sel=%b, want 10000", {bus.m_hready, bus.m_hresp, bus.mx_sel}); end
    endtask

    task automatic test_reset_in_hold();
        bus_idle();
        bus.mx_arb_grant = 2'b00;
        master_drive(NSEQ, 32'h1000_0000, 1'b0);
        tick();
        master_drive(IDLE, 32'h0, 1'b0);
        settle();
        checks++;
        if (bus.m_hready !== 1'b0)
            begin errors++; $display("FAIL rsthold_enter: got ready=%b, want 0", bus.m_hready); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        bus.mx_arb_grant = 2'b11;
        bus.s_hready     = 2'b00;
        bus.s_hrdata     = '1;
        for (int i = 0; i < 2; i++) begin
            settle();
            checks++;
            if (bus.m_hready !== 1'b1 || bus.mx_sel !== 2'b00 || bus.m_hrdata !== 32'h0)
                begin errors++; $display("FAIL rsthold_after%0d: got ready=%b sel=%b rdata=%h, want 1 00 0",
                    i, bus.m_hready, bus.mx_sel, bus.m_hrdata); end
            tick();
        end
    endtask

    task automatic test_random();
        xfer_t       pend[$];
        int unsigned dq[$];
        xfer_t       cur;
        logic [1:0]  e_trans;
        logic        e_ready;
        logic [1:0]  e_resp;
        logic [31:0] e_rdata;
        logic [1:0]  e_sel;
        int unsigned p;
        bus_idle();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            bus.m_htrans     = 2'($urandom_range(0, 3));
            bus.m_haddr      = $urandom;
            bus.m_hwrite     = 1'($urandom_range(0, 1));
            bus.m_hsize      = 3'($urandom_range(0, 7));
            bus.m_hburst     = 3'($urandom_range(0, 7));
            bus.m_hwdata     = $urandom;
            for (int k = 0; k < NB; k++) begin
                bus.mx_arb_grant[k] = ($urandom_range(0, 3) != 0);
                bus.s_hready[k]     = ($urandom_range(0, 3) != 0);
            end
            bus.s_hrdata = {$urandom, $urandom};
            bus.s_hresp  = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
            settle();

            e_resp  = 2'b00;
            e_rdata = 32'h0;
            if (pend.size() != 0) begin
                cur     = pend[0];
                e_trans = NSEQ;
                e_ready = 1'b0;
            end else begin
                cur     = '{bus.m_haddr, bus.m_hwrite, bus.m_hsize, bus.m_hburst};
                e_trans = bus.m_htrans;
                e_ready = 1'b1;
                if (dq.size() != 0) begin
                    e_ready = bus.s_hready[dq[0]];
                    e_resp  = bus.s_hresp[dq[0]*2 +: 2];
                    e_rdata = bus.s_hrdata[dq[0]*32 +: 32];
                end
            end
            p     = 32'(cur.addr[DB]);
            e_sel = (e_trans != IDLE) ? 2'(1 << p) : 2'b00;

            checks++;
            if ({bus.m_hready, bus.m_hresp} !== {e_ready, e_resp})
                begin errors++; $display("FAIL rnd_resp@%0d: got ready/resp=%b, want %b", n, {bus.m_hready, bus.m_hresp}, {e_ready, e_resp}); end
            if (pend.size() == 0) begin
                checks++;
                if (bus.m_hrdata !== e_rdata)
                    begin errors++; $display("FAIL rnd_rdata@%0d: got %h, want %h", n, bus.m_hrdata, e_rdata); end
            end
            checks++;
            if ({bus.mx_sel, bus.mx_htrans0} !== {e_sel, e_trans[0]})
                begin errors++; $display("FAIL rnd_sel@%0d: got sel/htrans0=%b, want %b", n, {bus.mx_sel, bus.mx_htrans0}, {e_sel, e_trans[0]}); end
            checks++;
            if ({bus.s_haddr, bus.s_htrans, bus.s_hwrite, bus.s_hsize, bus.s_hburst} !== {cur.addr, e_trans, cur.write, cur.size, cur.burst})
                begin errors++; $display("FAIL rnd_addr@%0d: got %h, want %h", n,
                    {bus.s_haddr, bus.s_htrans, bus.s_hwrite, bus.s_hsize, bus.s_hburst}, {cur.addr, e_trans, cur.write, cur.size, cur.burst}); end
            checks++;
            if (bus.s_hwdata !== bus.m_hwdata)
                begin errors++; $display("FAIL rnd_wdata@%0d: got %h, want %h", n, bus.s_hwdata, bus.m_hwdata); end

            // Advance the transaction model with this cycle's inputs.
            if (pend.size() != 0) begin
                if (bus.mx_arb_grant[p] && bus.s_hready[p]) begin
                    pend.delete();
                    dq.delete();
                    dq.push_back(p);
                end
            end else if (e_ready && bus.m_htrans[1]) begin
                dq.delete();
                if (bus.mx_arb_grant[p] && bus.s_hready[p]) dq.push_back(p);
                else pend.push_back(cur);
            end else if (dq.size() != 0 && bus.s_hready[dq[0]]) begin
                dq.delete();
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_hold();
        test_busy_burst();
        test_port_switch();
        test_error();
        test_reset_in_hold();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
